chan_err_ctrl: RTL and testbench
================================

CHAN_ERR_CTRL -- requirements
Module: chan_err_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-low reset; sampled on clk rising edge only.
REQ-004 Port start_i  input  1  one-cycle pulse; begins an injection run and latches all cfg_* inputs.
REQ-005 Port stop_i  input  1  aborts the active run; moves to DONE.
REQ-006 Port cfg_period_i  input  16  burst repetition period, in valid symbols.
REQ-007 Port cfg_burst_i  input  8  corrupted symbols at the start of each period.
REQ-008 Port cfg_mask_i  input  2  XOR pattern applied to corrupted symbols.
REQ-009 Port cfg_words_i  input  16  run length in valid symbols; 0 = unlimited.
REQ-010 Port sym_valid_i  input  1  encoder symbol valid.
REQ-011 Port sym_i  input  2  encoder output symbol {g1,g0}.
REQ-012 Port sym_valid_o  output  1  symbol valid to decoder.
REQ-013 Port sym_o  output  2  channel symbol to decoder (possibly corrupted).
REQ-014 Port busy_o  output  1  high in BURST or CLEAN.
REQ-015 Port done_o  output  1  one-cycle pulse at run end.
REQ-016 Port bit_err_ct_o  output  16  count of injected bit flips in the current or last run.
REQ-017 Port word_ct_o  output  16  count of valid symbols processed in the current or last run.

Function
REQ-018 States SHALL be IDLE, BURST, CLEAN and DONE.
REQ-019 sym_o and sym_valid_o SHALL be registered, with exactly 1-cycle latency from sym_i/sym_valid_i in every state.
REQ-020 In IDLE and DONE, and for any symbol processed in CLEAN, sym_o SHALL equal the delayed sym_i.
REQ-021 For a valid symbol processed in BURST, sym_o SHALL be sym_i XOR latched mask.
REQ-022 IDLE + start_i: latch cfg, clear both counters and period counter p; go to BURST if latched burst != 0, else to CLEAN.
REQ-023 A symbol arriving in the same cycle as start_i SHALL NOT be corrupted or counted.
REQ-024 Each valid symbol in BURST or CLEAN SHALL increment word_ct_o and p.
REQ-025 p SHALL wrap to 0 after reaching period-1.
REQ-026 BURST->CLEAN SHALL occur after the symbol with p == burst-1, unless burst >= period.
REQ-027 CLEAN->BURST SHALL occur after the symbol with p == period-1 when burst != 0.
REQ-028 If burst >= period, or period == 0, every symbol SHALL be corrupted; the FSM SHALL stay in BURST.
REQ-029 For each corrupted symbol, bit_err_ct_o SHALL add popcount(mask) (0..2); bit_err_ct_o SHALL saturate at 16'hFFFF.
REQ-030 word_ct_o SHALL saturate at 16'hFFFF; saturation SHALL NOT end an unlimited run.
REQ-031 If words != 0, the FSM SHALL go to DONE after the symbol that makes word_ct_o == words; that symbol SHALL be processed normally.
REQ-032 stop_i in BURST or CLEAN SHALL go to DONE; a symbol in the same cycle SHALL be processed and counted first.
REQ-033 DONE SHALL assert done_o for exactly one cycle and return to IDLE the next cycle.
REQ-034 Counters SHALL hold their values in IDLE until the next start_i.
REQ-035 start_i outside IDLE SHALL be ignored, and stop_i in IDLE SHALL be ignored.
REQ-036 Changes to cfg_* during a run SHALL have no effect.
REQ-037 sym_valid_i low SHALL freeze p, word_ct_o, bit_err_ct_o and the state, except for stop_i.

Reset
REQ-038 With rst low at a clock edge, the next state SHALL be: state IDLE, sym_o 0, sym_valid_o 0, busy_o 0, done_o 0, both counters 0, p 0, latched cfg 0.
REQ-039 Reset mid-run SHALL abort without a done_o pulse; any symbol in that cycle SHALL be dropped.
REQ-040 Reset SHALL take effect only on a clock edge, never asynchronously.

Verification
REQ-041 period=16, burst=2, mask=01, words=256, continuous valid -> first 2 of every 16 symbols XOR 01 at 1-cycle latency; word_ct=256, bit_err_ct=32; done_o one pulse.
REQ-042 burst=0, words=10, mask=11 -> sym_o == delayed sym_i throughout; bit_err_ct=0, word_ct=10, done_o after 10th valid symbol.
REQ-043 period=4, burst=6, mask=11, words=8 -> all 8 corrupted; bit_err_ct=16; FSM never enters CLEAN.
REQ-044 words=0, period=8, burst=1, mask=10; stop_i asserted with the 20th valid symbol -> word_ct=20, bit_err_ct=3, done_o next cycle, then IDLE.
REQ-045 rst low mid-run at word 5 -> next cycle all outputs and counters 0, no done_o; a later start_i runs normally.
REQ-046 sym_valid_i toggled 1/0 with period=4, burst=1, words=8 -> corrupted symbols at valid indices 0 and 4 only; cfg changes mid-run ignored.

Source files
------------

// File: rtl/chan_err_ctrl.sv
// chan_err_ctrl: channel error injector that sits between a convolutional
// encoder and its decoder. It forwards the 2-bit symbol stream with a fixed
// one-cycle delay. During a run, the first cfg_burst symbols of every
// cfg_period valid symbols are XORed with a mask. The block counts the
// valid symbols it processes and the bit flips it injects.
module chan_err_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [15:0] cfg_period_i,
  input  logic [7:0]  cfg_burst_i,
  input  logic [1:0]  cfg_mask_i,
  input  logic [15:0] cfg_words_i,
  input  logic        sym_valid_i,
  input  logic [1:0]  sym_i,
  output logic        sym_valid_o,
  output logic [1:0]  sym_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] word_ct_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_period;
  logic [7:0]  r_burst;
  logic [1:0]  r_mask;
  logic [15:0] r_words;
  logic [15:0] r_p;
  logic [15:0] r_word_ct;
  logic [15:0] r_bit_err_ct;
  logic [1:0]  r_sym;
  logic        r_sym_valid;

  logic        w_active;
  logic        w_proc;
  logic        w_corrupt;
  logic        w_all_burst;
  logic        w_p_last;
  logic        w_burst_end;
  logic        w_words_hit;
  logic [15:0] w_p_next;
  logic [15:0] w_word_next;
  logic [15:0] w_err_next;

  // Number of set bits in a 2-bit mask: the bit flips one corrupted symbol adds.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    popcount2 = {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  // Saturating 16-bit add of a small increment.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Per-symbol decode of the run state: processing, corruption and wrap points.
  always_comb begin
    w_active    = (r_state == ST_BURST) || (r_state == ST_CLEAN);
    w_proc      = w_active && sym_valid_i;
    w_corrupt   = w_proc && (r_state == ST_BURST);
    // A zero period, or a burst that fills the whole period, corrupts everything.
    w_all_burst = (r_period == 16'd0) || ({8'd0, r_burst} >= r_period);
    w_p_last    = (r_p == (r_period - 16'd1));
    w_burst_end = (r_p == ({8'd0, r_burst} - 16'd1));
    w_p_next    = w_p_last ? 16'd0 : (r_p + 16'd1);
    w_word_next = sat_add16(r_word_ct, 2'd1);
    w_err_next  = sat_add16(r_bit_err_ct, popcount2(r_mask));
    w_words_hit = (r_words != 16'd0) && (w_word_next == r_words);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The word limit and stop_i take priority over the
  // burst/clean toggling; the symbol in that cycle is still processed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next_state = (cfg_burst_i != 8'd0) ? ST_BURST : ST_CLEAN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_proc && w_words_hit) begin
          w_next_state = ST_DONE;
        end else if (stop_i) begin
          w_next_state = ST_DONE;
        end else if (w_proc && !w_all_burst && w_burst_end) begin
          w_next_state = ST_CLEAN;
        end else begin
          w_next_state = ST_BURST;
        end
      end
      ST_CLEAN: begin
        if (w_proc && w_words_hit) begin
          w_next_state = ST_DONE;
        end else if (stop_i) begin
          w_next_state = ST_DONE;
        end else if (w_proc && (r_burst != 8'd0) && w_p_last) begin
          w_next_state = ST_BURST;
        end else begin
          w_next_state = ST_CLEAN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: symbol delay line, config latch and run counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sym        <= 2'b00;
      r_sym_valid  <= 1'b0;
      r_period     <= 16'd0;
      r_burst      <= 8'd0;
      r_mask       <= 2'b00;
      r_words      <= 16'd0;
      r_p          <= 16'd0;
      r_word_ct    <= 16'd0;
      r_bit_err_ct <= 16'd0;
    end else begin
      r_sym_valid <= sym_valid_i;
      r_sym       <= sym_i ^ (w_corrupt ? r_mask : 2'b00);
      if ((r_state == ST_IDLE) && start_i) begin
        r_period     <= cfg_period_i;
        r_burst      <= cfg_burst_i;
        r_mask       <= cfg_mask_i;
        r_words      <= cfg_words_i;
        r_p          <= 16'd0;
        r_word_ct    <= 16'd0;
        r_bit_err_ct <= 16'd0;
      end else if (w_proc) begin
        r_p       <= w_p_next;
        r_word_ct <= w_word_next;
        if (w_corrupt) begin
          r_bit_err_ct <= w_err_next;
        end else begin
          r_bit_err_ct <= r_bit_err_ct;
        end
      end else begin
        r_p          <= r_p;
        r_word_ct    <= r_word_ct;
        r_bit_err_ct <= r_bit_err_ct;
      end
    end
  end

  // Output decode. Everything is driven from registers, so there is no
  // combinational path from the inputs to the outputs.
  always_comb begin
    sym_o        = r_sym;
    sym_valid_o  = r_sym_valid;
    busy_o       = (r_state == ST_BURST) || (r_state == ST_CLEAN);
    done_o       = (r_state == ST_DONE);
    bit_err_ct_o = r_bit_err_ct;
    word_ct_o    = r_word_ct;
  end

endmodule

// File: tb/tb_chan_err_ctrl.sv
// Directed testbench for chan_err_ctrl. Inputs change 1 ns after each rising
// edge, and the outputs are sampled at the same point.
module tb_chan_err_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        stop_i;
  logic [15:0] cfg_period_i;
  logic [7:0]  cfg_burst_i;
  logic [1:0]  cfg_mask_i;
  logic [15:0] cfg_words_i;
  logic        sym_valid_i;
  logic [1:0]  sym_i;
  logic        sym_valid_o;
  logic [1:0]  sym_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bit_err_ct_o;
  logic [15:0] word_ct_o;

  int n_tests;
  int n_fail;

  chan_err_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .cfg_period_i (cfg_period_i),
    .cfg_burst_i  (cfg_burst_i),
    .cfg_mask_i   (cfg_mask_i),
    .cfg_words_i  (cfg_words_i),
    .sym_valid_i  (sym_valid_i),
    .sym_i        (sym_i),
    .sym_valid_o  (sym_valid_o),
    .sym_o        (sym_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bit_err_ct_o (bit_err_ct_o),
    .word_ct_o    (word_ct_o)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] per, input logic [7:0] bur,
                         input logic [1:0] msk, input logic [15:0] wds);
    cfg_period_i = per;
    cfg_burst_i  = bur;
    cfg_mask_i   = msk;
    cfg_words_i  = wds;
  endtask

  initial begin
    logic [1:0] s;
    logic [1:0] e;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; sym_valid_i = 1'b0; sym_i = 2'b00;
    set_cfg(16'd0, 8'd0, 2'b00, 16'd0);

    // ---- reset state
    tick(); tick();
    chk("rst_sym", {14'd0, sym_o}, 16'd0);
    chk("rst_vld", {15'd0, sym_valid_o}, 16'd0);
    chk("rst_busy", {15'd0, busy_o}, 16'd0);
    chk("rst_done", {15'd0, done_o}, 16'd0);
    chk("rst_wct", word_ct_o, 16'd0);
    chk("rst_ect", bit_err_ct_o, 16'd0);
    rst = 1'b1;
    tick();

    // ---- A: period 16, burst 2, mask 01, words 256, continuous valid
    set_cfg(16'd16, 8'd2, 2'b01, 16'd256);
    start_i = 1'b1; sym_valid_i = 1'b1; sym_i = 2'b11;
    tick();
    start_i = 1'b0;
    chk("A_startsym", {14'd0, sym_o}, 16'd3);
    chk("A_busy0", {15'd0, busy_o}, 16'd1);
    chk("A_wct0", word_ct_o, 16'd0);
    for (int i = 0; i < 256; i++) begin
      s = i[1:0];
      sym_i = s;
      start_i = (i == 100);
      tick();
      e = s ^ (((i % 16) < 2) ? 2'b01 : 2'b00);
      chk("A_sym", {14'd0, sym_o}, {14'd0, e});
      chk("A_done", {15'd0, done_o}, {15'd0, (i == 255)});
    end
    start_i = 1'b0;
    chk("A_wct", word_ct_o, 16'd256);
    chk("A_ect", bit_err_ct_o, 16'd32);
    sym_valid_i = 1'b0;
    tick();
    chk("A_done_gone", {15'd0, done_o}, 16'd0);
    chk("A_idle", {15'd0, busy_o}, 16'd0);
    chk("A_wct_hold", word_ct_o, 16'd256);

    // ---- B: burst 0, words 10, mask 11 -> no corruption
    set_cfg(16'd5, 8'd0, 2'b11, 16'd10);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("B_busy", {15'd0, busy_o}, 16'd1);
    chk("B_wct0", word_ct_o, 16'd0);
    sym_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = i[1:0];
      sym_i = s;
      tick();
      chk("B_sym", {14'd0, sym_o}, {14'd0, s});
      chk("B_done", {15'd0, done_o}, {15'd0, (i == 9)});
    end
    chk("B_wct", word_ct_o, 16'd10);
    chk("B_ect", bit_err_ct_o, 16'd0);
    sym_valid_i = 1'b0;
    tick();

    // ---- C: period 4, burst 6, mask 11, words 8 -> all corrupted
    set_cfg(16'd4, 8'd6, 2'b11, 16'd8);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sym_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = i[1:0];
      sym_i = s;
      tick();
      chk("C_sym", {14'd0, sym_o}, {14'd0, s ^ 2'b11});
      chk("C_done", {15'd0, done_o}, {15'd0, (i == 7)});
    end
    chk("C_wct", word_ct_o, 16'd8);
    chk("C_ect", bit_err_ct_o, 16'd16);
    sym_valid_i = 1'b0;
    tick();

    // ---- D: unlimited run, period 8, burst 1, mask 10, stop with 20th symbol
    set_cfg(16'd8, 8'd1, 2'b10, 16'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sym_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = i[1:0];
      sym_i = s;
      stop_i = (i == 19);
      tick();
      e = s ^ (((i % 8) == 0) ? 2'b10 : 2'b00);
      chk("D_sym", {14'd0, sym_o}, {14'd0, e});
      chk("D_done", {15'd0, done_o}, {15'd0, (i == 19)});
    end
    stop_i = 1'b0;
    chk("D_wct", word_ct_o, 16'd20);
    chk("D_ect", bit_err_ct_o, 16'd3);
    sym_i = 2'b01;
    tick();
    chk("D_done_gone", {15'd0, done_o}, 16'd0);
    chk("D_idle", {15'd0, busy_o}, 16'd0);
    chk("D_idle_sym", {14'd0, sym_o}, 16'd1);
    chk("D_wct_hold", word_ct_o, 16'd20);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("D_stop_idle_done", {15'd0, done_o}, 16'd0);
    chk("D_stop_idle_busy", {15'd0, busy_o}, 16'd0);

    // ---- E: reset mid-run at word 5, then a clean rerun
    sym_valid_i = 1'b0;
    set_cfg(16'd4, 8'd1, 2'b01, 16'd100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sym_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sym_i = i[1:0];
      tick();
    end
    chk("E_wct5", word_ct_o, 16'd5);
    rst = 1'b0; sym_i = 2'b11;
    tick();
    chk("E_rst_vld", {15'd0, sym_valid_o}, 16'd0);
    chk("E_rst_sym", {14'd0, sym_o}, 16'd0);
    chk("E_rst_busy", {15'd0, busy_o}, 16'd0);
    chk("E_rst_done", {15'd0, done_o}, 16'd0);
    chk("E_rst_wct", word_ct_o, 16'd0);
    chk("E_rst_ect", bit_err_ct_o, 16'd0);
    rst = 1'b1; sym_valid_i = 1'b0;
    tick();
    chk("E_nodone1", {15'd0, done_o}, 16'd0);
    tick();
    chk("E_nodone2", {15'd0, done_o}, 16'd0);
    set_cfg(16'd2, 8'd1, 2'b11, 16'd3);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sym_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = i[1:0] + 2'd1;
      sym_i = s;
      tick();
      e = s ^ (((i % 2) == 0) ? 2'b11 : 2'b00);
      chk("E_sym", {14'd0, sym_o}, {14'd0, e});
      chk("E_done", {15'd0, done_o}, {15'd0, (i == 2)});
    end
    chk("E_wct", word_ct_o, 16'd3);
    chk("E_ect", bit_err_ct_o, 16'd4);
    sym_valid_i = 1'b0;
    tick();

    // ---- F: toggling valid, period 4, burst 1, words 8; cfg changed mid-run
    set_cfg(16'd4, 8'd1, 2'b01, 16'd8);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    set_cfg(16'd2, 8'd2, 2'b11, 16'd3);
    for (int i = 0; i < 16; i++) begin
      int v;
      v = i / 2;
      s = v[1:0];
      sym_i = s;
      sym_valid_i = ((i % 2) == 0);
      tick();
      chk("F_vld", {15'd0, sym_valid_o}, {15'd0, ((i % 2) == 0)});
      if ((i % 2) == 0) begin
        e = s ^ (((v == 0) || (v == 4)) ? 2'b01 : 2'b00);
        chk("F_sym", {14'd0, sym_o}, {14'd0, e});
      end
      chk("F_done", {15'd0, done_o}, {15'd0, (i == 14)});
    end
    chk("F_wct", word_ct_o, 16'd8);
    chk("F_ect", bit_err_ct_o, 16'd2);
    chk("F_idle", {15'd0, busy_o}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
